// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and widths for the RC4 keystream consumer.
//   rc4_xor_state_t : controller FSM states
//   RC4_KEY_W       : key width in bits
//   RC4_LEN_W       : message length / byte counter width in bits
//   cntWidth()      : counter width able to hold values 0..maxVal
package rc4_pkg;

    localparam int unsigned RC4_KEY_W = 32;
    localparam int unsigned RC4_LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KSA_WAIT,
        ST_WAIT_DATA,
        ST_PRGA_REQ,
        ST_PRGA_WAIT,
        ST_OUT_HOLD,
        ST_DONE
    } rc4_xor_state_t;

    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/rc4_wdog_counter.sv
// rc4_wdog_counter: loadable down-counter used as a wait watchdog.
//   clk, n_rst : clock, synchronous active-low reset
//   load       : load loadVal (takes priority over counting)
//   loadVal    : value loaded; expiry comes loadVal+1 enabled cycles later
//   enable     : count down while high
//   expire     : high while enabled with the count exhausted
module rc4_wdog_counter #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/rc4_stream_xor_ctrl.sv
// rc4_stream_xor_ctrl: drives the RC4 generator request side and XORs each
// returned keystream byte with one ciphertext byte to produce plaintext.
//   clk, n_rst            : clock, synchronous active-low reset
//   start_i               : start pulse (honoured only when idle)
//   rc4_key_i, msg_len_i  : key and byte count, latched on accepted start
//   genStateArr_o         : level request for state-array build
//   sarrGenerated_i       : state array ready
//   genVal_o              : one-cycle keystream byte request
//   valReady_i, keystream_i : keystream byte and its valid strobe
//   rc4_key_o             : latched key to the generator
//   cipher_i/_valid_i/_ready_o : ciphertext byte stream in
//   plain_o/_valid_o, plain_ready_i : plaintext byte stream out
//   busy_o, done_o, error_o : status (error is sticky until next start)
module rc4_stream_xor_ctrl
    import rc4_pkg::*;
#(
    parameter int unsigned KSA_TIMEOUT  = 2048,
    parameter int unsigned PRGA_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_i,
    input  logic [RC4_KEY_W-1:0] rc4_key_i,
    input  logic [RC4_LEN_W-1:0] msg_len_i,
    output logic                 genStateArr_o,
    input  logic                 sarrGenerated_i,
    output logic                 genVal_o,
    input  logic                 valReady_i,
    input  logic [7:0]           keystream_i,
    output logic [RC4_KEY_W-1:0] rc4_key_o,
    input  logic [7:0]           cipher_i,
    input  logic                 cipher_valid_i,
    output logic                 cipher_ready_o,
    output logic [7:0]           plain_o,
    output logic                 plain_valid_o,
    input  logic                 plain_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int unsigned WDOG_MAX = (KSA_TIMEOUT > PRGA_TIMEOUT) ? KSA_TIMEOUT : PRGA_TIMEOUT;
    localparam int unsigned WDOG_W   = cntWidth(WDOG_MAX);
    // Loading TIMEOUT-1 makes expire fire on the TIMEOUT-th cycle in the wait state.
    localparam logic [WDOG_W-1:0] KSA_LOAD  = WDOG_W'(KSA_TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] PRGA_LOAD = WDOG_W'(PRGA_TIMEOUT - 1);

    rc4_xor_state_t state, nextState;

    logic [RC4_LEN_W-1:0] msgLen;
    logic [RC4_LEN_W-1:0] byteCnt;
    logic [RC4_LEN_W:0]   cntPlusOne;
    logic [7:0]           cipherByte;

    logic              startAccept;
    logic              cipherAccept;
    logic              ksAccept;
    logic              outAccept;
    logic              setError;
    logic              wdogLoad;
    logic [WDOG_W-1:0] wdogLoadVal;
    logic              wdogEn;
    logic              wdogExpire;

    // Extra bit keeps counter+1 from wrapping when len is 65535.
    assign cntPlusOne = {1'b0, byteCnt} + (RC4_LEN_W + 1)'(1);

    // Kept outside the FSM block so expire does not feed back into it.
    assign wdogEn = (state == ST_KSA_WAIT) || (state == ST_PRGA_WAIT);

    rc4_wdog_counter #(
        .WIDTH(WDOG_W)
    ) uWdog (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (wdogLoad),
        .loadVal (wdogLoadVal),
        .enable  (wdogEn),
        .expire  (wdogExpire)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        genStateArr_o  = 1'b0;
        genVal_o       = 1'b0;
        cipher_ready_o = 1'b0;
        plain_valid_o  = 1'b0;
        done_o         = 1'b0;
        busy_o         = (state != ST_IDLE);
        startAccept    = 1'b0;
        cipherAccept   = 1'b0;
        ksAccept       = 1'b0;
        outAccept      = 1'b0;
        setError       = 1'b0;
        wdogLoad       = 1'b0;
        wdogLoadVal    = KSA_LOAD;

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    startAccept = 1'b1;
                    if (msg_len_i == '0) begin
                        nextState = ST_DONE;
                    end else begin
                        nextState   = ST_KSA_WAIT;
                        wdogLoad    = 1'b1;
                        wdogLoadVal = KSA_LOAD;
                    end
                end
            end
            ST_KSA_WAIT: begin
                genStateArr_o = 1'b1;
                // Ready is checked first so it wins over a same-cycle expiry.
                if (sarrGenerated_i) begin
                    nextState = ST_WAIT_DATA;
                end else if (wdogExpire) begin
                    setError  = 1'b1;
                    nextState = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                cipher_ready_o = 1'b1;
                if (cipher_valid_i) begin
                    cipherAccept = 1'b1;
                    nextState    = ST_PRGA_REQ;
                end
            end
            ST_PRGA_REQ: begin
                genVal_o    = 1'b1;
                wdogLoad    = 1'b1;
                wdogLoadVal = PRGA_LOAD;
                nextState   = ST_PRGA_WAIT;
            end
            ST_PRGA_WAIT: begin
                if (valReady_i) begin
                    ksAccept  = 1'b1;
                    nextState = ST_OUT_HOLD;
                end else if (wdogExpire) begin
                    setError  = 1'b1;
                    nextState = ST_IDLE;
                end
            end
            ST_OUT_HOLD: begin
                plain_valid_o = 1'b1;
                if (plain_ready_i) begin
                    outAccept = 1'b1;
                    nextState = (cntPlusOne == {1'b0, msgLen}) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                done_o    = 1'b1;
                nextState = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rc4_key_o  <= '0;
            msgLen     <= '0;
            byteCnt    <= '0;
            cipherByte <= '0;
            plain_o    <= '0;
            error_o    <= 1'b0;
        end else begin
            if (startAccept) begin
                rc4_key_o <= rc4_key_i;
                msgLen    <= msg_len_i;
                byteCnt   <= '0;
                error_o   <= 1'b0;
            end
            if (setError) begin
                error_o <= 1'b1;
            end
            if (cipherAccept) begin
                cipherByte <= cipher_i;
            end
            if (ksAccept) begin
                plain_o <= cipherByte ^ keystream_i;
            end
            if (outAccept) begin
                byteCnt <= byteCnt + RC4_LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_xor_ctrl.sv
// tb_rc4_stream_xor_ctrl: directed bench for rc4_stream_xor_ctrl with a
// generator stub, an XOR reference queue and a per-cycle compare process.
module tb_rc4_stream_xor_ctrl;

    localparam int unsigned KSA_TO  = 64;
    localparam int unsigned PRGA_TO = 6;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start_i;
    logic [31:0] rc4_key_i;
    logic [15:0] msg_len_i;
    logic        genStateArr_o;
    logic        sarrGenerated_i;
    logic        genVal_o;
    logic        valReady_i;
    logic [7:0]  keystream_i;
    logic [31:0] rc4_key_o;
    logic [7:0]  cipher_i;
    logic        cipher_valid_i;
    logic        cipher_ready_o;
    logic [7:0]  plain_o;
    logic        plain_valid_o;
    logic        plain_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    rc4_stream_xor_ctrl #(
        .KSA_TIMEOUT  (KSA_TO),
        .PRGA_TIMEOUT (PRGA_TO)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .start_i         (start_i),
        .rc4_key_i       (rc4_key_i),
        .msg_len_i       (msg_len_i),
        .genStateArr_o   (genStateArr_o),
        .sarrGenerated_i (sarrGenerated_i),
        .genVal_o        (genVal_o),
        .valReady_i      (valReady_i),
        .keystream_i     (keystream_i),
        .rc4_key_o       (rc4_key_o),
        .cipher_i        (cipher_i),
        .cipher_valid_i  (cipher_valid_i),
        .cipher_ready_o  (cipher_ready_o),
        .plain_o         (plain_o),
        .plain_valid_o   (plain_valid_o),
        .plain_ready_i   (plain_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrlOuts();
        return {genStateArr_o, genVal_o, cipher_ready_o, plain_valid_o, busy_o, done_o, error_o};
    endfunction

    // Generator stub configuration and bookkeeping.
    int  ksaDelay  = 10;
    bit  prgaNever = 1'b0;
    int  ksaCnt    = 0;
    int  ksaLast   = 0;
    int  ksaTotal  = 0;
    int  gvCount   = 0;
    bit  valPend   = 1'b0;
    logic [7:0] ksQ[$];

    // Reference model: expected plaintext = cipher XOR keystream, in order.
    logic [7:0] cq[$];
    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    int  hsCycles[$];
    int  remaining = 0;
    bit  doneDue   = 1'b0;
    bit  checkEn   = 1'b0;
    int  cyc       = 0;

    logic [7:0] stC[4];
    logic [7:0] stK[4];
    logic [7:0] stP[4];

    // Generator stub: answers the state-array request after ksaDelay cycles
    // (never if 0) and each keystream request one cycle later.
    always @(negedge clk) begin
        if (!n_rst) begin
            valPend         = 1'b0;
            valReady_i      = 1'b0;
            sarrGenerated_i = 1'b0;
            ksaCnt          = 0;
        end else begin
            sarrGenerated_i = 1'b0;
            if (genStateArr_o) begin
                ksaCnt++;
                ksaTotal++;
                if (ksaDelay != 0 && ksaCnt == ksaDelay) sarrGenerated_i = 1'b1;
            end else if (ksaCnt != 0) begin
                ksaLast = ksaCnt;
                ksaCnt  = 0;
            end
            valReady_i  = 1'b0;
            keystream_i = 8'hEE;
            if (valPend && !prgaNever) begin
                valReady_i  = 1'b1;
                keystream_i = (ksQ.size() != 0) ? ksQ.pop_front() : 8'h00;
            end
            valPend = genVal_o;
            if (genVal_o) gvCount++;
        end
    end

    // Per-cycle compare against the reference model.
    bit prevGenVal = 1'b0;
    bit prevValReady = 1'b0;
    bit prevPV = 1'b0;
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (checkEn) begin
            chk("done_pulse", 64'(done_o), 64'(doneDue));
            doneDue = 1'b0;
            if (genVal_o) chk("genval_width", 64'(prevGenVal), 64'd0);
            if (prevValReady || (plain_valid_o && !prevPV))
                chk("vr_to_pv", 64'({prevValReady, plain_valid_o}), 64'd3);
            if (plain_valid_o && plain_ready_i) begin
                if (expQ.size() == 0) chk("plain_unexpected", 64'(plain_o), 64'hFFFF);
                else chk("plain_data", 64'(plain_o), 64'(expQ.pop_front()));
                gotQ.push_back(plain_o);
                hsCycles.push_back(cyc);
                if (remaining > 0) begin
                    remaining--;
                    if (remaining == 0) doneDue = 1'b1;
                end
            end
        end
        prevGenVal   = genVal_o;
        prevValReady = valReady_i;
        prevPV       = plain_valid_o;
    end

    task automatic startMsg(input logic [31:0] key, input logic [15:0] len);
        start_i   = 1'b1;
        rc4_key_i = key;
        msg_len_i = len;
        @(negedge clk);
        start_i   = 1'b0;
        rc4_key_i = ~key;
        msg_len_i = 16'hFFFF;
        if (len == 0) doneDue = 1'b1;
        #1;
        chk("start_key", 64'(rc4_key_o), 64'(key));
        chk("start_err_clr", 64'(error_o), 64'd0);
        chk("start_busy", 64'(busy_o), 64'd1);
        chk("start_ksa_req", 64'(genStateArr_o), 64'(len != 0));
    endtask

    task automatic sendBytes(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            cipher_i       = cq.pop_front();
            cipher_valid_i = 1'b1;
            #1;
            while (!cipher_ready_o && w < 300) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (!cipher_ready_o) begin
                chk("cipher_accept_to", 64'(cipher_ready_o), 64'd1);
                break;
            end
            @(negedge clk);
        end
        cipher_valid_i = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!done_o && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_o), 64'd1);
    endtask

    task automatic waitGenVal(input string name);
        int w;
        w = 0;
        #1;
        while (!genVal_o && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk(name, 64'(genVal_o), 64'd1);
    endtask

    int gvStart;
    int ksaStart;
    int n;

    initial begin
        n_rst = 1'b0; start_i = 1'b0; rc4_key_i = '0; msg_len_i = '0;
        cipher_i = '0; cipher_valid_i = 1'b0; plain_ready_i = 1'b1;
        sarrGenerated_i = 1'b0; valReady_i = 1'b0; keystream_i = '0;
        stC = '{8'h00, 8'hFF, 8'h5A, 8'hA5};
        stK = '{8'h12, 8'h34, 8'h56, 8'h78};
        stP = '{8'h12, 8'hCB, 8'h0C, 8'hDD};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", 64'(ctrlOuts()), 64'd0);
        chk("rst_plain", 64'(plain_o), 64'd0);
        chk("rst_key", 64'(rc4_key_o), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        checkEn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte, key "DR.J"
        ksaDelay = 10;
        cq.push_back(8'h3C); ksQ.push_back(8'hA5); expQ.push_back(8'h3C ^ 8'hA5);
        remaining = 1; gotQ.delete();
        startMsg(32'h44522E4A, 16'd1);
        sendBytes(1);
        waitDone(50);
        chk("single_ksa_wait", 64'(ksaLast), 64'd10);
        chk("single_plain", 64'((gotQ.size() > 0) ? gotQ[0] : 8'h00), 64'h99);
        chk("single_drained", 64'(expQ.size()), 64'd0);
        repeat (2) @(negedge clk);

        // Four-byte stream, no backpressure
        gotQ.delete(); hsCycles.delete();
        for (int i = 0; i < 4; i++) begin
            cq.push_back(stC[i]); ksQ.push_back(stK[i]); expQ.push_back(stC[i] ^ stK[i]);
        end
        remaining = 4; gvStart = gvCount;
        startMsg(32'h01234567, 16'd4);
        sendBytes(4);
        waitDone(50);
        chk("stream_count", 64'(gotQ.size()), 64'd4);
        if (gotQ.size() == 4)
            for (int i = 0; i < 4; i++) chk("stream_plain", 64'(gotQ[i]), 64'(stP[i]));
        chk("stream_genval_pulses", 64'(gvCount - gvStart), 64'd4);
        if (hsCycles.size() == 4)
            for (int i = 0; i < 3; i++) chk("stream_rate", 64'(hsCycles[i+1] - hsCycles[i]), 64'd4);
        repeat (2) @(negedge clk);

        // Backpressure
        cq.push_back(8'h11); cq.push_back(8'h22);
        ksQ.push_back(8'h0F); ksQ.push_back(8'hF0);
        expQ.push_back(8'h11 ^ 8'h0F); expQ.push_back(8'h22 ^ 8'hF0);
        remaining = 2; gvStart = gvCount; plain_ready_i = 1'b0;
        startMsg(32'hCAFE0001, 16'd2);
        fork
            sendBytes(2);
            begin
                n = 0;
                @(negedge clk);
                #1;
                while (!plain_valid_o && n < 100) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("bp_valid_seen", 64'(plain_valid_o), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_plain_hold", 64'(plain_o), 64'h1E);
                    chk("bp_valid_hold", 64'(plain_valid_o), 64'd1);
                    chk("bp_cipher_ready", 64'(cipher_ready_o), 64'd0);
                end
                chk("bp_genval_count", 64'(gvCount - gvStart), 64'd1);
                plain_ready_i = 1'b1;
            end
        join
        waitDone(50);
        repeat (2) @(negedge clk);

        // Start while busy is ignored
        cq.push_back(8'hAB); cq.push_back(8'hCD);
        ksQ.push_back(8'h01); ksQ.push_back(8'h02);
        expQ.push_back(8'hAB ^ 8'h01); expQ.push_back(8'hCD ^ 8'h02);
        remaining = 2;
        startMsg(32'h0BADF00D, 16'd2);
        @(negedge clk);
        start_i = 1'b1; rc4_key_i = 32'h76543210; msg_len_i = 16'd5;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("busy_start_key", 64'(rc4_key_o), 64'h0BADF00D);
        chk("busy_start_req", 64'(genStateArr_o), 64'd1);
        sendBytes(2);
        waitDone(50);
        chk("busy_start_key_end", 64'(rc4_key_o), 64'h0BADF00D);
        repeat (2) @(negedge clk);

        // State-array timeout
        ksaDelay = 0; remaining = 0;
        startMsg(32'h11112222, 16'd3);
        n = 0;
        while (!error_o && n < int'(KSA_TO) + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ksa_err", 64'(error_o), 64'd1);
        chk("ksa_to_cycles", 64'(ksaLast), 64'(KSA_TO));
        chk("ksa_to_idle", 64'(busy_o), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ksa_err_sticky", 64'(error_o), 64'd1);

        // Zero length: next start clears error, no state-array request
        ksaStart = ksaTotal;
        @(negedge clk);
        startMsg(32'h33334444, 16'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("len0_no_ksa", 64'(ksaTotal - ksaStart), 64'd0);
        chk("len0_idle", 64'(busy_o), 64'd0);

        // Keystream timeout
        @(negedge clk);
        ksaDelay = 3; prgaNever = 1'b1; remaining = 0;
        cq.push_back(8'h77);
        startMsg(32'h55556666, 16'd1);
        sendBytes(1);
        waitGenVal("prga_genval_seen");
        n = 0;
        while (!error_o && n < int'(PRGA_TO) + 20) begin
            @(negedge clk);
            #1;
            n++;
            if (plain_valid_o) chk("prga_to_no_output", 64'(plain_valid_o), 64'd0);
        end
        chk("prga_err", 64'(error_o), 64'd1);
        chk("prga_to_cycles", 64'(n), 64'(PRGA_TO + 1));
        chk("prga_to_idle", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);

        // Reset held 2 cycles while waiting for keystream
        cq.push_back(8'h55);
        startMsg(32'h77778888, 16'd1);
        sendBytes(1);
        waitGenVal("rst_genval_seen");
        repeat (2) @(negedge clk);
        checkEn = 1'b0;
        n_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rst_mid_ctrl", 64'(ctrlOuts()), 64'd0);
            chk("rst_mid_plain", 64'(plain_o), 64'd0);
            chk("rst_mid_key", 64'(rc4_key_o), 64'd0);
        end
        n_rst = 1'b1;
        prgaNever = 1'b0; expQ.delete(); ksQ.delete(); remaining = 0; doneDue = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_release_idle", 64'(ctrlOuts()), 64'd0);
        checkEn = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/rc4_stream_xor_ctrl.md
# rc4_stream_xor_ctrl

Keystream consumer for the RC4 datapath. It drives the pseudo-random generator's request side (state-array build, then one keystream byte per data byte) and XORs each returned keystream byte with an incoming ciphertext byte to emit plaintext. It sits between the byte-stream source, the RC4 generator, and the downstream consumer (e.g. the Sobel front end).

## Interface
Parameters:
- KSA_TIMEOUT, 2048: max cycles to wait for `sarrGenerated_i` after the state-array request.
- PRGA_TIMEOUT, 16: max cycles to wait for `valReady_i` after a keystream request.

Ports:
- clk  in  1  system clock; single clock domain.
- n_rst  in  1  reset; **synchronous, active-low**.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- rc4_key_i  in  32  key, latched on an accepted start.
- msg_len_i  in  16  byte count, latched on an accepted start.
- genStateArr_o  out  1  level request to build the state array; connects to generator `genStateArr_i`.
- sarrGenerated_i  in  1  state array ready; from the generator.
- genVal_o  out  1  one-cycle keystream-byte request; connects to generator `genVal_i`.
- valReady_i  in  1  keystream byte valid this cycle.
- keystream_i  in  8  keystream byte; from generator `outputToXor_o`.
- rc4_key_o  out  32  latched key to the generator.
- cipher_i  in  8  ciphertext byte.
- cipher_valid_i  in  1  ciphertext valid.
- cipher_ready_o  out  1  ciphertext accepted when high together with valid.
- plain_o  out  8  plaintext byte.
- plain_valid_o  out  1  plaintext valid.
- plain_ready_i  in  1  downstream ready.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the last byte is handed off.
- error_o  out  1  sticky timeout flag; cleared by the next accepted start or by reset.

## Operation
- States: IDLE, KSA_WAIT, WAIT_DATA, PRGA_REQ, PRGA_WAIT, OUT_HOLD, DONE.
- IDLE: on `start_i`, latch key, length, and clear `error_o`.
  - msg_len_i==0: go to DONE.
  - Otherwise: go to KSA_WAIT.
- KSA_WAIT: `genStateArr_o`=1.
  - On `sarrGenerated_i`: drop the request and go to WAIT_DATA.
  - On watchdog expiry: set `error_o` and go to IDLE.
- WAIT_DATA: `cipher_ready_o`=1. On valid&ready, capture the byte and go to PRGA_REQ.
- PRGA_REQ: `genVal_o`=1 for exactly one cycle, then go to PRGA_WAIT.
- PRGA_WAIT:
  - On `valReady_i`: `plain_o` <= captured byte XOR `keystream_i`, registered. Go to OUT_HOLD.
  - On timeout: set `error_o`, go to IDLE, output nothing.
- OUT_HOLD: `plain_valid_o`=1, with `plain_o` stable until `plain_ready_i`. On handshake, increment the byte counter.
  - counter==len: go to DONE.
  - Otherwise: go to WAIT_DATA.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- Byte counter: 16-bit unsigned, cleared on start. Compare using counter+1==len at the handshake, so no wrap is possible for len ≤ 65535.
- `start_i` outside IDLE is ignored.
- `valReady_i` outside PRGA_WAIT is ignored.
- Only one keystream request is outstanding at a time.

## Timing
- Reset (n_rst=0 at a clk edge):
  - State returns to IDLE.
  - All 1-bit outputs are 0; `plain_o`=0 and `rc4_key_o`=0.
  - Counters are cleared.
  - Reset mid-transfer abandons the message with no `done_o`.
- Start to `genStateArr_o`: high on the cycle after the start edge.
- `valReady_i` to `plain_valid_o`: 1 cycle, because the XOR result is registered.
- With the generator answering in 1 cycle and no backpressure, throughput is 1 byte per 4 cycles.
- Watchdogs count cycles in KSA_WAIT and PRGA_WAIT only. Expiry occurs on the cycle the count reaches the parameter. The count restarts on each state entry.
- Simultaneous ready and timeout in the same cycle: ready wins.
- `done_o` asserts the cycle after the final output handshake.

## Structure
- `rc4_pkg`:
  - state enum `rc4_xor_state_t`
  - `RC4_KEY_W`=32
  - `RC4_LEN_W`=16
- Sub-module `rc4_wdog_counter`: loadable down-counter with an `expire` output. One instance is shared by KSA_WAIT and PRGA_WAIT, loaded with the appropriate parameter on state entry.
- Top-level file holds the FSM, the byte counter, and the data registers.

## Test plan
- Reset: hold n_rst=0 for 2 cycles mid-PRGA_WAIT → all outputs are 0 and state is IDLE the next cycle; no `done_o`.
- Single byte: key="DR.J", len=1; generator stub returns `sarrGenerated_i` after 10 cycles and keystream 0xA5; cipher 0x3C → `plain_o`=0x99, `plain_valid_o` 1 cycle after `valReady_i`, then `done_o` pulse.
- Stream of 4 bytes (0x00, 0xFF, 0x5A, 0xA5) against keystream 0x12, 0x34, 0x56, 0x78 → outputs 0x12, 0xCB, 0x0C, 0xDD. Exactly 4 `genVal_o` pulses, each 1 cycle wide.
- Backpressure: hold `plain_ready_i`=0 for 5 cycles → `plain_o` stays stable, `cipher_ready_o`=0, and no extra `genVal_o`.
- Timeouts:
  - Stub never raises `sarrGenerated_i` → `error_o`=1 at cycle KSA_TIMEOUT and return to IDLE.
  - Stub never raises `valReady_i` → `error_o` at PRGA_TIMEOUT.
  - The next start clears `error_o`.
- Boundaries:
  - len=0 → `done_o` with no `genStateArr_o`.
  - `start_i` pulsed while busy → ignored and the latched key is unchanged.
